// File: rtl/adc_chain_ctrl.sv
// Run controller for the CIC -> comp -> HB1 -> HB2 decimation chain: flush, settle-discard,
// rescale/saturate to DW_OUT bits and deliver on a single-register valid/ready output.
module adc_chain_ctrl #(
    parameter int DW_IN     = 35,
    parameter int DW_OUT    = 32,
    parameter int SHIFT     = 3,
    parameter int FLUSH_CYC = 64,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_en,
    input  logic [CNT_W-1:0]    cfg_discard_n,
    input  logic                ovr_clr,
    output logic                chain_rstn,
    input  logic                chain_vld_in,
    input  logic [DW_IN-1:0]    chain_dat_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW_OUT-1:0]   out_data,
    output logic                sat_flag,
    output logic                overrun,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic                busy
);

    localparam int FW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

    state_t              state, next_state;
    logic [FW-1:0]       flush_cnt;
    logic [CNT_W-1:0]    disc_cnt;

    logic signed [DW_IN-1:0] shifted;
    logic [DW_IN-DW_OUT:0]   upper;
    logic                    fits;
    logic [DW_OUT-1:0]       sat_data;
    logic                    accept, xfer, load, drop;

    // Saturation: the value fits when every bit above the output sign bit matches it.
    assign shifted  = $signed(chain_dat_in) >>> SHIFT;
    assign upper    = shifted[DW_IN-1:DW_OUT-1];
    assign fits     = (&upper) | ~(|upper);
    assign sat_data = fits ? shifted[DW_OUT-1:0]
                    : (shifted[DW_IN-1] ? {1'b1, {(DW_OUT-1){1'b0}}}
                                        : {1'b0, {(DW_OUT-1){1'b1}}});

    assign accept = (state == RUN) && cfg_en && chain_vld_in;
    assign xfer   = out_valid && out_ready;
    assign load   = accept && (!out_valid || out_ready);
    assign drop   = accept && out_valid && !out_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cfg_en) next_state = FLUSH;
            FLUSH:   if (!cfg_en) next_state = IDLE;
                     else if (flush_cnt == FW'(FLUSH_CYC - 1))
                         next_state = (disc_cnt != '0) ? SETTLE : RUN;
            SETTLE:  if (!cfg_en) next_state = IDLE;
                     else if (chain_vld_in && disc_cnt == CNT_W'(1)) next_state = RUN;
            RUN:     if (!cfg_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            chain_rstn <= 1'b0;
            flush_cnt  <= '0;
            disc_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            sat_flag   <= 1'b0;
            overrun    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state      <= next_state;
            chain_rstn <= (next_state == SETTLE) || (next_state == RUN);

            if (state == IDLE && cfg_en) begin
                disc_cnt  <= cfg_discard_n;
                flush_cnt <= '0;
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else if (state == SETTLE && chain_vld_in) begin
                disc_cnt <= disc_cnt - 1'b1;
            end

            if (xfer) sample_cnt <= sample_cnt + 1'b1;

            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;

            // Leaving for IDLE discards whatever sample is still pending.
            if (!cfg_en)   out_valid <= 1'b0;
            else if (load) out_valid <= 1'b1;
            else if (xfer) out_valid <= 1'b0;

            if (load) begin
                out_data <= sat_data;
                sat_flag <= ~fits;
            end
        end
    end

endmodule

// File: tb/tb_adc_chain_ctrl.sv
// Directed bench for adc_chain_ctrl: a SHIFT=0 instance for control/saturation and a SHIFT=3
// instance sharing the same stimulus for arithmetic-shift rescaling.
module tb_adc_chain_ctrl;

    logic        clk = 1'b0;
    logic        rstn, cfg_en, ovr_clr, chain_vld_in, out_ready;
    logic [15:0] cfg_discard_n;
    logic [34:0] chain_dat_in;

    logic        chain_rstn, out_valid, sat_flag, overrun, busy;
    logic [31:0] out_data;
    logic [15:0] sample_cnt;

    logic        chain_rstn3, out_valid3, sat_flag3, overrun3, busy3;
    logic [31:0] out_data3;
    logic [15:0] sample_cnt3;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int flen;

    always #5 clk = ~clk;

    adc_chain_ctrl #(.SHIFT(0)) dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_discard_n(cfg_discard_n),
        .ovr_clr(ovr_clr), .chain_rstn(chain_rstn), .chain_vld_in(chain_vld_in),
        .chain_dat_in(chain_dat_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .overrun(overrun),
        .sample_cnt(sample_cnt), .busy(busy)
    );

    adc_chain_ctrl #(.SHIFT(3)) dut3 (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_discard_n(cfg_discard_n),
        .ovr_clr(ovr_clr), .chain_rstn(chain_rstn3), .chain_vld_in(chain_vld_in),
        .chain_dat_in(chain_dat_in), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .sat_flag(sat_flag3), .overrun(overrun3),
        .sample_cnt(sample_cnt3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [34:0] v);
        chain_vld_in = 1'b1;
        chain_dat_in = v;
        step(1);
        chain_vld_in = 1'b0;
    endtask

    // Called just after the FLUSH entry edge; counts edges until chain_rstn rises.
    task automatic wait_flush(output int n);
        n = 0;
        while (!chain_rstn && n < 200) begin
            step(1);
            n++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_chain_rstn"}, chain_rstn, 0);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_out_data"},   out_data,   0);
        check({tag, "_sat_flag"},   sat_flag,   0);
        check({tag, "_overrun"},    overrun,    0);
        check({tag, "_sample_cnt"}, sample_cnt, 0);
        check({tag, "_busy"},       busy,       0);
    endtask

    initial begin
        rstn = 1'b0; cfg_en = 1'b0; ovr_clr = 1'b0; chain_vld_in = 1'b0;
        out_ready = 1'b1; cfg_discard_n = 16'd3; chain_dat_in = '0;
        step(2);
        check_reset("reset");
        check("reset3_state", {chain_rstn3, out_valid3, overrun3, busy3, sample_cnt3}, 0);

        // Start: 64-cycle flush, discard 3, deliver samples 4 and 5.
        rstn = 1'b1; cfg_en = 1'b1;
        step(1);
        check("flush_busy", busy, 1);
        check("flush_chain_rstn", chain_rstn, 0);
        wait_flush(flen);
        check("flush_len_1", flen, 64);
        for (int k = 1; k <= 5; k++) begin
            strobe(35'(k));
            if (k == 3) check("settle_no_out", out_valid, 0);
            if (k == 4) check("first_out", {out_valid, out_data}, {1'b1, 32'd4});
            if (k == 5) check("second_out", {out_valid, out_data}, {1'b1, 32'd5});
            step(7);
        end
        check("cnt_after_start", sample_cnt, 2);

        // Saturation on SHIFT=0, exact fit on SHIFT=3.
        strobe(35'h3_FFFF_FFF8);
        check("sat_pos", {sat_flag, out_data}, {1'b1, 32'h7FFF_FFFF});
        check("shift3_pos", {sat_flag3, out_data3}, {1'b0, 32'h7FFF_FFFF});
        step(1);
        strobe(35'h4_0000_0000);
        check("sat_neg", {sat_flag, out_data}, {1'b1, 32'h8000_0000});
        check("shift3_neg", {sat_flag3, out_data3}, {1'b0, 32'h8000_0000});
        step(1);
        strobe(35'h7_FFFF_FFF0);
        check("no_sat_neg16", {sat_flag, out_data}, {1'b0, 32'hFFFF_FFF0});
        check("shift3_neg16", {sat_flag3, out_data3}, {1'b0, 32'hFFFF_FFFE});
        step(1);
        check("cnt_after_sat", sample_cnt, 5);

        // Backpressure and overrun; clear coinciding with a new overrun keeps it set.
        out_ready = 1'b0;
        strobe(35'd100);
        step(2);
        check("bp_hold", {out_valid, out_data}, {1'b1, 32'd100});
        strobe(35'd200);
        check("bp_overrun", {overrun, out_data}, {1'b1, 32'd100});
        ovr_clr = 1'b1;
        strobe(35'd300);
        ovr_clr = 1'b0;
        check("ovr_set_wins", {overrun, out_data}, {1'b1, 32'd100});
        out_ready = 1'b1;
        step(1);
        check("bp_drain", {out_valid, sample_cnt}, {1'b0, 16'd6});
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Transfer and new strobe in the same cycle.
        out_ready = 1'b0;
        strobe(35'd7);
        out_ready = 1'b1;
        strobe(35'd9);
        check("simul_load", {out_valid, overrun, out_data}, {2'b10, 32'd9});
        step(1);
        check("simul_cnt", {out_valid, sample_cnt}, {1'b0, 16'd8});

        // Abort in RUN with a pending sample and a set overrun.
        out_ready = 1'b0;
        strobe(35'd11);
        strobe(35'd12);
        cfg_en = 1'b0;
        step(1);
        check("abort_run", {busy, chain_rstn, out_valid}, 3'b000);
        check("abort_keep", {overrun, sample_cnt}, {1'b1, 16'd8});

        // Restart with discard 2, abort inside SETTLE.
        cfg_discard_n = 16'd2; cfg_en = 1'b1;
        step(1);
        wait_flush(flen);
        check("flush_len_2", flen, 64);
        strobe(35'd13);
        check("settle_mid", {busy, out_valid}, 2'b10);
        cfg_en = 1'b0;
        step(1);
        check("abort_settle", {busy, chain_rstn}, 2'b00);

        // Restart with no discard: first strobe after flush is delivered.
        cfg_discard_n = 16'd0; cfg_en = 1'b1; out_ready = 1'b1; ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("ovr_clr_idle", overrun, 0);
        wait_flush(flen);
        check("flush_len_3", flen, 64);
        strobe(35'd21);
        check("run_no_discard", {out_valid, out_data}, {1'b1, 32'd21});
        step(1);
        check("cnt_run", sample_cnt, 9);

        // Reset in RUN with a pending sample and overrun set.
        out_ready = 1'b0;
        strobe(35'd33);
        strobe(35'd34);
        check("pre_reset_ovr", overrun, 1);
        rstn = 1'b0;
        step(1);
        check_reset("midrun");

        // Counter wrap: 65535 transfers, then one more.
        rstn = 1'b1; out_ready = 1'b1;
        step(1);
        wait_flush(flen);
        check("flush_len_4", flen, 64);
        chain_vld_in = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            chain_dat_in = 35'(i);
            step(1);
        end
        chain_vld_in = 1'b0;
        step(2);
        check("cnt_max", sample_cnt, 16'hFFFF);
        strobe(35'd1);
        step(1);
        check("cnt_wrap", sample_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
